// File: rtl/cpu_step_ctrl.sv
// Execution-enable controller: turns slow-clock edges (run) or debounced button
// presses (step) into single-cycle cpu_en pulses, stops on halt, counts issued cycles.
module cpu_step_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             slow_clk,
    input  logic             mode,
    input  logic             step_btn,
    input  logic             halt,
    output logic             cpu_en,
    output logic             btn_clean,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] cycle_cnt
);
    localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        STEP = 2'b10,
        HALT = 2'b11
    } state_t;

    state_t          state_q, state_d;
    logic            btn_meta, btn_s, btn_clean_d, slow_d;
    logic [DB_W-1:0] db_cnt;
    logic            slow_edge, press, issue;

    assign slow_edge = slow_clk & ~slow_d;
    assign press     = btn_clean & ~btn_clean_d;
    assign state     = state_q;

    // Synchroniser, debouncer and edge-detect history run in every state, HALT included.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_meta    <= 1'b0;
            btn_s       <= 1'b0;
            btn_clean   <= 1'b0;
            btn_clean_d <= 1'b0;
            db_cnt      <= '0;
            slow_d      <= 1'b0;
        end else begin
            btn_meta    <= step_btn;
            btn_s       <= btn_meta;
            btn_clean_d <= btn_clean;
            slow_d      <= slow_clk;
            if (btn_s == btn_clean) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                btn_clean <= btn_s;
                db_cnt    <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

    // Priority halt > mode change > issue; an event coinciding with a transition is dropped.
    // NOTE: defaults first so no path through this block leaves a latch behind.
    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        unique case (state_q)
            IDLE: state_d = mode ? STEP : RUN;
            RUN: begin
                if (halt)      state_d = HALT;
                else if (mode) state_d = STEP;
                else           issue   = slow_edge;
            end
            STEP: begin
                if (halt)       state_d = HALT;
                else if (!mode) state_d = RUN;
                else            issue   = press;
            end
            HALT: state_d = HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cpu_en    <= 1'b0;
            cycle_cnt <= '0;
        end else begin
            state_q <= state_d;
            cpu_en  <= issue;
            if (cpu_en) cycle_cnt <= cycle_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Self-checking bench for cpu_step_ctrl: directed scenarios plus randomized traffic,
// compared every cycle against a window-based behavioural model.
module tb_cpu_step_ctrl;
    localparam int D     = 4;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst, slow_clk, mode, step_btn, halt;
    logic             cpu_en, btn_clean;
    logic [1:0]       state;
    logic [CNT_W-1:0] cycle_cnt;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int pulses = 0;
    int pulse_times[$];

    cpu_step_ctrl #(.DEBOUNCE_CYCLES(D), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .slow_clk(slow_clk), .mode(mode), .step_btn(step_btn),
        .halt(halt), .cpu_en(cpu_en), .btn_clean(btn_clean), .state(state),
        .cycle_cnt(cycle_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural model: mode 0 idle, 1 run, 2 step, 3 halt. Debounce is a sliding
    // window of synchronised samples that must all disagree with the clean level.
    int m_state, m_cnt;
    bit m_en, m_clean, m_clean_d, m_slow_d, m_s1, m_s2;
    bit win[$];
    bit m_rise, m_press, m_go, m_all;
    int m_nxt;

    always @(posedge clk) begin
        if (rst) begin
            m_state = 0; m_cnt = 0; m_en = 0; m_clean = 0; m_clean_d = 0;
            m_slow_d = 0; m_s1 = 0; m_s2 = 0;
            win.delete();
        end else begin
            m_rise  = slow_clk && !m_slow_d;
            m_press = m_clean && !m_clean_d;
            m_go    = 0;
            m_nxt   = m_state;
            if (m_state == 0) m_nxt = mode ? 2 : 1;
            else if (m_state == 3) m_nxt = 3;
            else if (halt) m_nxt = 3;
            else if (mode != (m_state == 2)) m_nxt = mode ? 2 : 1;
            else m_go = (m_state == 1) ? m_rise : m_press;
            m_cnt = (m_cnt + (m_en ? 1 : 0)) % (1 << CNT_W);
            m_en = m_go;
            m_state = m_nxt;
            m_clean_d = m_clean;
            win.push_back(m_s2);
            if (win.size() > D) void'(win.pop_front());
            m_all = (win.size() == D);
            foreach (win[i]) if (win[i] == m_clean) m_all = 0;
            if (m_all) m_clean = !m_clean;
            m_s2 = m_s1;
            m_s1 = step_btn;
            m_slow_d = slow_clk;
        end
    end

    always @(negedge clk) begin
        cyc++;
        check("cpu_en", cpu_en, m_en);
        check("btn_clean", btn_clean, m_clean);
        check("state", state, m_state);
        check("cycle_cnt", cycle_cnt, m_cnt);
        if (cpu_en) begin
            pulses++;
            pulse_times.push_back(cyc);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic do_reset(input logic m);
        @(negedge clk);
        rst = 1; mode = m; slow_clk = 0; halt = 0; step_btn = 0;
        cycles(3);
        rst = 0;
    endtask

    task automatic run_pulse();
        @(negedge clk); slow_clk = 1;
        @(negedge clk); slow_clk = 0;
        cycles(3);
    endtask

    int p0, rise_at, en_at, en_cnt;

    initial begin
        rst = 1; slow_clk = 0; mode = 1; step_btn = 0; halt = 0;
        cycles(3);
        check("reset_state", state, 0);
        check("reset_cpu_en", cpu_en, 0);
        check("reset_cnt", cycle_cnt, 0);
        check("reset_clean", btn_clean, 0);

        // Glitch of 3 samples must not reach btn_clean with a 4-sample debounce.
        rst = 0;
        cycles(5);
        p0 = pulses;
        step_btn = 1; cycles(3); step_btn = 0;
        cycles(20);
        check("glitch_clean", btn_clean, 0);
        check("glitch_pulses", pulses - p0, 0);
        check("glitch_cnt", cycle_cnt, 0);

        // Held press: clean rises 2+D edges after the rise, one pulse the edge after.
        p0 = pulses; rise_at = 0; en_at = 0; en_cnt = 0;
        step_btn = 1;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            if (btn_clean && rise_at == 0) rise_at = k;
            if (cpu_en) begin en_cnt++; if (en_at == 0) en_at = k; end
        end
        step_btn = 0;
        cycles(20);
        check("step_rise_edge", rise_at, 6);
        check("step_en_edge", en_at, 7);
        check("step_pulse_count", en_cnt, 1);
        check("step_total_pulses", pulses - p0, 1);
        check("step_cnt", cycle_cnt, 1);

        // Run mode: slow clock period 10, 100 cycles.
        do_reset(0);
        p0 = pulses;
        pulse_times.delete();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            slow_clk = ((i / 5) % 2) == 1;
        end
        @(negedge clk); slow_clk = 0;
        cycles(3);
        check("run_pulses", pulses - p0, 10);
        check("run_cnt", cycle_cnt, 10);
        for (int i = 1; i < pulse_times.size(); i++)
            check("run_spacing", pulse_times[i] - pulse_times[i-1], 10);

        // Halt arriving together with a slow edge.
        p0 = pulses;
        @(negedge clk); slow_clk = 1; halt = 1;
        @(negedge clk); halt = 0; slow_clk = 0;
        cycles(2);
        check("halt_state", state, 3);
        check("halt_no_pulse", pulses - p0, 0);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            slow_clk = ((i / 5) % 2) == 1;
        end
        check("halt_absorbing", state, 3);
        check("halt_200_pulses", pulses - p0, 0);

        // Mode flip on a slow-edge cycle.
        do_reset(0);
        cycles(4);
        p0 = pulses;
        slow_clk = 1; mode = 1;
        cycles(3);
        slow_clk = 0;
        check("mode_no_pulse", pulses - p0, 0);
        check("mode_state", state, 2);

        // Reset while cpu_en is high.
        do_reset(0);
        cycles(4);
        slow_clk = 1;
        @(negedge clk);
        check("pre_reset_en", cpu_en, 1);
        rst = 1; slow_clk = 0;
        @(negedge clk);
        check("mid_reset_en", cpu_en, 0);
        check("mid_reset_cnt", cycle_cnt, 0);
        check("mid_reset_state", state, 0);
        check("mid_reset_clean", btn_clean, 0);
        rst = 0;

        // Counter wrap at 4 bits.
        do_reset(0);
        cycles(3);
        for (int i = 0; i < 15; i++) run_pulse();
        check("wrap_at_15", cycle_cnt, 15);
        for (int i = 0; i < 2; i++) run_pulse();
        check("wrap_at_17", cycle_cnt, 1);

        // Randomized traffic checked every cycle by the model.
        do_reset(0);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            slow_clk = ((i / 5) % 2) == 1;
            if ($urandom_range(0, 6) == 0) step_btn = ~step_btn;
            if ($urandom_range(0, 99) == 0) mode = ~mode;
            halt = ($urandom_range(0, 499) == 0);
            rst  = ($urandom_range(0, 299) == 0);
        end
        rst = 0; halt = 0;
        cycles(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cpu_step_ctrl.md
# cpu_step_ctrl

Execution-enable controller placed directly downstream of the divide-by-10 clock generator. It turns the slow clock's rising edges (run mode) or debounced step-button presses (step mode) into single-cycle `cpu_en` pulses on the fast clock. These pulses gate the single-cycle CPU's state updates. It also stops issuing on a CPU halt and counts executed cycles for the display logic.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive stable samples required before the debounced button level changes. Legal range is 2..65535.
- `CNT_W`, default 32: width of the executed-cycle counter.
- `clk`  in  1: fast system clock; all logic is on its rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `slow_clk`  in  1: divided clock level, produced in the `clk` domain. It is sampled, never used as a clock.
- `mode`  in  1: 0 = run, 1 = single-step.
- `step_btn`  in  1: raw asynchronous push-button.
- `halt`  in  1: level from the CPU requesting a permanent stop.
- `cpu_en`  out  1: one-`clk`-wide execute pulse.
- `btn_clean`  out  1: debounced button level.
- `state`  out  2: FSM state for LEDs (00 IDLE, 01 RUN, 10 STEP, 11 HALT).
- `cycle_cnt`  out  CNT_W: number of `cpu_en` pulses issued since reset.

## Operation
- **Button synchroniser:** two flops, `step_btn` to `btn_s`.
- **Debouncer:**
  - Counter width is ceil(log2(DEBOUNCE_CYCLES)).
  - If `btn_s` == `btn_clean`, the counter clears.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1, `btn_clean` takes `btn_s` on that same edge and the counter clears.
  - Net effect: `btn_clean` changes only after exactly DEBOUNCE_CYCLES consecutive disagreeing samples.
- **Press event:** `btn_clean` is 1 and its one-cycle-delayed copy is 0.
- **Slow edge event:** `slow_clk` is 1 and the registered `slow_d` is 0. `slow_d` updates every cycle in all states.
- **FSM** (registered state; priority is halt > mode change > issue):
  - IDLE: unconditionally goes to RUN if `mode`=0, or to STEP if `mode`=1. Never issues.
  - RUN:
    - `halt` goes to HALT.
    - Else `mode`=1 goes to STEP.
    - Else a slow edge sets `cpu_en` next cycle.
  - STEP:
    - `halt` goes to HALT.
    - Else `mode`=0 goes to RUN.
    - Else a press event sets `cpu_en` next cycle.
  - HALT: absorbing until `rst`. `cpu_en` stays 0 and the debouncer keeps running.
- **No pulse on transitions:** no `cpu_en` is generated in the cycle an event coincides with a state transition. The event is dropped, not queued.
- **Cycle counter:** `cycle_cnt` increments by 1 in the cycle after `cpu_en` is sampled high. It wraps modulo 2^CNT_W silently.

## Timing
- **Reset values:**
  - `state`=IDLE, `cpu_en`=0, `cycle_cnt`=0, `btn_clean`=0.
  - Debounce counter=0, synchroniser flops=0.
  - `slow_d`=0.
- **Reset priority:** reset overrides everything, including mid-debounce and mid-pulse. A `cpu_en` high on the reset edge is cleared and is not counted.
- **Run latency:** `slow_clk` is first sampled high at edge N, so `cpu_en`=1 during the cycle after edge N, for exactly one cycle.
- **Run pulse rate:** with the divide-by-10 source, pulses repeat every 10 `clk` cycles.
- **Step latency:** `step_btn` rises and stays high. `btn_clean` rises 2 + DEBOUNCE_CYCLES edges later, and `cpu_en` rises one edge after that.
- **Step pulse count:** exactly one pulse per press regardless of hold length. Release generates nothing.
- **Halt response:** `halt` sampled at edge N moves `state` to HALT at edge N. Any edge or press at edge N is suppressed. A pulse already launched at edge N-1 still completes and is counted.
- **First state:** the first post-reset edge always lands in IDLE, so a slow edge or press in that cycle is ignored.

## Test plan
- **Debounce glitch rejection:** DEBOUNCE_CYCLES=4, STEP mode, `step_btn` high for 3 cycles then low. Required: `btn_clean` stays 0, no `cpu_en`, `cycle_cnt`=0.
- **Step press:** STEP mode, `step_btn` held high 50 cycles then released. Required: `btn_clean` rises at edge 6 after the rise, exactly one `cpu_en` pulse the following cycle, `cycle_cnt`=1.
- **Run mode:** `slow_clk` toggling every 5 cycles for 100 cycles. Required: 10 `cpu_en` pulses spaced exactly 10 cycles apart, each one cycle after a sampled rising edge, `cycle_cnt`=10.
- **Halt collision:** RUN mode, `halt` asserted in the same cycle as a slow edge. Required: no pulse, `state`=11, and no further pulses over 200 cycles.
- **Mode switch and reset mid-operation:**
  - Flip `mode` 0 to 1 on a slow-edge cycle. Required: no pulse, `state`=10.
  - Assert `rst` while `cpu_en`=1. Required: next cycle all outputs are at reset values and `cycle_cnt`=0.
- **Counter wrap:** CNT_W=4, run for 17 pulses. Required: `cycle_cnt` reads 15 after pulse 15 and 1 after pulse 17.
